// File: rtl/bcd_split_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Converts a 10-bit value to hundreds/tens/ones digits, saturating above 999.
module bcd_split_seq (
    input  logic       Clk_In,
    input  logic       Reset_In,
    input  logic       Start_In,
    input  logic [9:0] Bin_In,
    output logic       Busy_Out,
    output logic       Done_Out,
    output logic       Ovf_Out,
    output logic [3:0] Hundreds_Out,
    output logic [3:0] Tens_Out,
    output logic [3:0] Ones_Out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [9:0] MAX_BCD = 10'd999;
    localparam logic [3:0] LAST_SHIFT = 4'd9;

    state_t      state_q;
    state_t      state_d;
    logic [9:0]  bin_q;
    logic [9:0]  bin_d;
    logic [11:0] scr_q;
    logic [11:0] scr_d;
    logic [11:0] scr_adj;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic        ovf_q;
    logic        ovf_d;
    logic [3:0]  hun_d;
    logic [3:0]  ten_d;
    logic [3:0]  one_d;
    logic        ovf_out_d;
    logic        done_d;

    // Add 3 to a nibble that would reach 10 or more once doubled.
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Per-nibble correction, all nibbles judged on their pre-shift values.
    always_comb begin
        scr_adj = {add3(scr_q[11:8]), add3(scr_q[7:4]), add3(scr_q[3:0])};
    end

    // Next-state and datapath updates for the conversion sequence.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scr_d     = scr_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        hun_d     = Hundreds_Out;
        ten_d     = Tens_Out;
        one_d     = Ones_Out;
        ovf_out_d = Ovf_Out;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Start_In) begin
                    bin_d   = Bin_In;
                    scr_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = (Bin_In > MAX_BCD);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // The thousands carry out of scr_adj[11] is dropped.
                {scr_d, bin_d} = {scr_adj[10:0], bin_q, 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_SHIFT) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                if (ovf_q) begin
                    hun_d = 4'd9;
                    ten_d = 4'd9;
                    one_d = 4'd9;
                end else begin
                    hun_d = scr_q[11:8];
                    ten_d = scr_q[7:4];
                    one_d = scr_q[3:0];
                end
                ovf_out_d = ovf_q;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, working registers and held outputs; reset clears everything.
    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            state_q      <= IDLE;
            bin_q        <= '0;
            scr_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            Hundreds_Out <= '0;
            Tens_Out     <= '0;
            Ones_Out     <= '0;
            Ovf_Out      <= 1'b0;
            Done_Out     <= 1'b0;
        end else begin
            state_q      <= state_d;
            bin_q        <= bin_d;
            scr_q        <= scr_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            Hundreds_Out <= hun_d;
            Tens_Out     <= ten_d;
            Ones_Out     <= one_d;
            Ovf_Out      <= ovf_out_d;
            Done_Out     <= done_d;
        end
    end

    // Busy covers the shift and finish phases.
    always_comb begin
        Busy_Out = (state_q != IDLE);
    end

endmodule
